one_n_demux: RTL

ONE_N_DEMUX -- requirements
Module: one_n_demux

---
 rtl/one_n_demux_if.sv | 48 ++++
 rtl/one_n_demux.sv | 99 +++++++++
 2 files changed

// File: rtl/one_n_demux_if.sv
// Bus bundle for one_n_demux: control/data inputs and the registered lane bank.
// The optional par signal exists only when ONE_N_DEMUX_PARITY_EN is defined.
interface one_n_demux_if #(
    parameter int N = 3,
    parameter int P = 2 ** N
);
    logic         start;
    logic         din_valid;
    logic         din;
    logic [N-1:0] sel;
    logic [P-1:0] out;
    logic         busy;
    logic         done;
    logic [N-1:0] cnt;
`ifdef ONE_N_DEMUX_PARITY_EN
    logic         par;
`endif

    // Stimulus side: drives requests and data, observes the lane bank.
    modport master (
        output start,
        output din_valid,
        output din,
        output sel,
        input  out,
        input  busy,
        input  done,
`ifdef ONE_N_DEMUX_PARITY_EN
        input  par,
`endif
        input  cnt
    );

    // Demux side.
    modport slave (
        input  start,
        input  din_valid,
        input  din,
        input  sel,
        output out,
        output busy,
        output done,
`ifdef ONE_N_DEMUX_PARITY_EN
        output par,
`endif
        output cnt
    );
endinterface

// File: rtl/one_n_demux.sv
// 1-to-P serial demux with a registered lane bank.
// Direct mode (IDLE): each valid bit lands in lane sel.
// Frame mode (FILL): valid bits fill lanes 0..P-1 in order, then DONE pulses for one cycle.
// Optional feature: define ONE_N_DEMUX_PARITY_EN to add a registered XOR-reduction output par.
module one_n_demux #(
    parameter int N = 3,
    parameter int P = 2 ** N
) (
    input  logic         clk,
    input  logic         rst,
    one_n_demux_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StDone
    } state_e;

    localparam logic [N-1:0] CntLast = N'(P - 1);
    localparam logic [N-1:0] CntOne  = N'(1);

    state_e       state_q, state_d;
    logic [P-1:0] out_q, out_d;
    logic [N-1:0] cnt_q, cnt_d;

    // Next-state and lane-write decode; start only takes effect from IDLE.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StFill;
                    cnt_d   = '0;
                end else if (bus.din_valid) begin
                    out_d[bus.sel] = bus.din;
                end
            end
            StFill: begin
                if (bus.din_valid) begin
                    out_d[cnt_q] = bus.din;
                    if (cnt_q == CntLast) begin
                        cnt_d   = '0;
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, lane bank and frame index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            out_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.cnt  = cnt_q;
    assign bus.busy = (state_q == StFill);
    assign bus.done = (state_q == StDone);

`ifdef ONE_N_DEMUX_PARITY_EN
    logic par_q, par_d;

    // Parity tracks the next lane bank so it changes on the same edge as out.
    always_comb begin
        par_d = ^out_d;
    end

    // Parity register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign bus.par = par_q;
`endif

endmodule
